hsv_core_flush_fifo: RTL and testbench

- Parameterised ready/valid FIFO placed between pipeline stages (issue→exec, exec→commit).
- Acts as the responder end of the global flush handshake: it sees flush_req from ctrlstatus, discards all buffered entries, and returns flush_ack using the four-phase req/ack protocol.
- Every pipeline-stage ack (flush_ack_alu, flush_ack_mem, ...) can be driven by one instance of this block or by logic built on it.

---
 rtl/hsv_core_flush_fifo.sv | 142 ++++++++++++++
 tb/tb_hsv_core_flush_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_core_flush_fifo.sv
// hsv_core_flush_fifo: ready/valid FIFO between pipeline stages that acts as
// the responder end of the four-phase flush_req/flush_ack handshake.
// Optional macro HSV_CORE_FIFO_WATERMARK_EN adds the max_level watermark port.
module hsv_core_flush_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_core,
    input  logic                         rst_core,
    input  logic                         flush_req,
    output logic                         flush_ack,
    input  logic [WIDTH-1:0]             in,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [WIDTH-1:0]             out,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef HSV_CORE_FIFO_WATERMARK_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   max_level
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push;
    logic             pop;

    // State register.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake gating; flush_req blocks traffic in the same cycle.
    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        case (state)
            RUN: begin
                if (flush_req) begin
                    state_next = FLUSH;
                end else begin
                    ready_o = (level != LW'(DEPTH));
                    valid_o = (level != '0);
                end
            end
            FLUSH: begin
                if (!flush_req) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = flush_req ? FLUSH : RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;
    assign out  = mem[rd_ptr];

    // Registered acknowledge: high for every cycle spent in FLUSH.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            flush_ack <= 1'b0;
        end else begin
            flush_ack <= (state_next == FLUSH);
        end
    end

    // Pointers and occupancy; everything buffered is discarded on the way into FLUSH.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (state_next == FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    // Payload storage; contents are meaningless until written.
    always_ff @(posedge clk_core) begin
        if (push) begin
            mem[wr_ptr] <= in;
        end
    end

    // Occupancy must never overflow or underflow.
    always_ff @(posedge clk_core) begin
        if (!rst_core) begin
            assert (!(push && !pop && (level == LW'(DEPTH))) && !(pop && !push && (level == '0)));
        end
    end

`ifdef HSV_CORE_FIFO_WATERMARK_EN
    // Highest occupancy since reset; deliberately survives flushes.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            max_level <= '0;
        end else if (level > max_level) begin
            max_level <= level;
        end
    end
`endif

endmodule

// File: tb/tb_hsv_core_flush_fifo.sv
// Self-checking bench for hsv_core_flush_fifo: directed steps plus random
// traffic, compared against a queue-based reference model.
module tb_hsv_core_flush_fifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic             clk_core;
    logic             rst_core;
    logic             flush_req;
    logic             flush_ack;
    logic [WIDTH-1:0] din;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] dout;
    logic             valid_o;
    logic             ready_i;
    logic [LW-1:0]    level;
`ifdef HSV_CORE_FIFO_WATERMARK_EN
    logic [LW-1:0]    max_level;
`endif

    hsv_core_flush_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_core  (clk_core),
        .rst_core  (rst_core),
        .flush_req (flush_req),
        .flush_ack (flush_ack),
        .in        (din),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .out       (dout),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .level     (level)
`ifdef HSV_CORE_FIFO_WATERMARK_EN
        ,
        .max_level (max_level)
`endif
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    int errors = 0;
    int checks = 0;

    // Reference model: queue contents, ack = previous flush_req,
    // release cycle = previous ack with flush_req low, watermark as running max.
    logic [WIDTH-1:0] q[$];
    bit               m_ack = 1'b0;
    bit               m_rel = 1'b0;
    int               mx    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ack = 1'b0;
        m_rel = 1'b0;
        mx    = 0;
    endtask

    // One clock: drive at negedge, check all outputs, then advance the model.
    task automatic step(input bit req, input bit vin, input logic [WIDTH-1:0] d, input bit rdy);
        bit run;
        bit rexp;
        bit vexp;
        bit do_push;
        bit do_pop;
        @(negedge clk_core);
        flush_req = req;
        valid_i   = vin;
        din       = d;
        ready_i   = rdy;
        #1;
        run  = !m_ack && !m_rel && !req;
        rexp = run && (q.size() < DEPTH);
        vexp = run && (q.size() > 0);
        chk("ready_o", 64'(ready_o), 64'(rexp));
        chk("valid_o", 64'(valid_o), 64'(vexp));
        chk("flush_ack", 64'(flush_ack), 64'(m_ack));
        chk("level", 64'(level), 64'(q.size()));
        if (vexp) chk("out", 64'(dout), 64'(q[0]));
`ifdef HSV_CORE_FIFO_WATERMARK_EN
        chk("max_level", 64'(max_level), 64'(mx));
`endif
        @(posedge clk_core);
        do_push = vin && rexp;
        do_pop  = vexp && rdy;
        if (q.size() > mx) mx = q.size();
        if (req) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        m_rel = m_ack && !req;
        m_ack = req;
    endtask

    task automatic do_reset();
        @(negedge clk_core);
        rst_core  = 1'b1;
        flush_req = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        #1;
        model_reset();
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid_o", 64'(valid_o), 64'd0);
        chk("rst_flush_ack", 64'(flush_ack), 64'd0);
`ifdef HSV_CORE_FIFO_WATERMARK_EN
        chk("rst_max_level", 64'(max_level), 64'd0);
`endif
        @(negedge clk_core);
        rst_core = 1'b0;
    endtask

    initial begin
        bit req_r;
        rst_core  = 1'b1;
        flush_req = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        din       = '0;
        model_reset();

        // Power-on reset
        #12;
        chk("por_level", 64'(level), 64'd0);
        chk("por_valid_o", 64'(valid_o), 64'd0);
        chk("por_flush_ack", 64'(flush_ack), 64'd0);
        @(negedge clk_core);
        rst_core = 1'b0;
        #1;
        chk("por_ready_o", 64'(ready_o), 64'd1);

        // Fill with downstream stalled, then an extra push that must be refused
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'('hA0 + i), 1'b0);
        step(1'b0, 1'b1, 32'hEE, 1'b0);
        #1;
        chk("fill_level", 64'(level), 64'd4);
        chk("fill_ready_o", 64'(ready_o), 64'd0);

        // Drain in order
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);

        // Level 2 with simultaneous push/pop across several pointer wraps
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, $urandom, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);

        // Flush at level 3; stale data must never appear afterwards
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'('hB0 + i), 1'b0);
        step(1'b1, 1'b1, 32'hBAD0, 1'b1);
        step(1'b1, 1'b1, 32'hBAD1, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 32'hBAD2, 1'b1);
        step(1'b0, 1'b1, 32'hBAD3, 1'b1);
        step(1'b0, 1'b1, 32'hC0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);

        // Re-assert during the release cycle
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'hD0, 1'b0);
        step(1'b1, 1'b1, 32'hD1, 1'b0);
        step(1'b1, 1'b1, 32'hD2, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);

        // Flush while full, and a push racing a rising flush into an empty FIFO
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'('hE0 + i), 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 32'hDD, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Asynchronous reset in the middle of a flush
        step(1'b0, 1'b1, 32'hF0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        #2;
        chk("mid_flush_ack", 64'(flush_ack), 64'(m_ack));
        rst_core = 1'b1;
        #1;
        chk("async_flush_ack", 64'(flush_ack), 64'd0);
        chk("async_valid_o", 64'(valid_o), 64'd0);
        chk("async_level", 64'(level), 64'd0);
        model_reset();
        @(negedge clk_core);
        rst_core  = 1'b0;
        flush_req = 1'b0;

        // Watermark scenario: fill to 3, drain, flush, fill to 1
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, $urandom, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
`ifdef HSV_CORE_FIFO_WATERMARK_EN
        #1;
        chk("wm_max_level", 64'(max_level), 64'd3);
`endif
        do_reset();

        // Random traffic with occasional flush bursts
        req_r = 1'b0;
        for (int i = 0; i < 800; i++) begin
            req_r = ($urandom_range(0, 24) == 0) || (req_r && ($urandom_range(0, 2) != 0));
            step(req_r, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
